// File: rtl/serial_memory_loader_pkg.sv
// Shared constants and state type for the serial memory loader.
package serial_memory_loader_pkg;

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] CmdPause = 8'h50;
    localparam logic [7:0] CmdGo    = 8'h47;
    localparam logic [7:0] RespAck  = 8'h06;
    localparam logic [7:0] RespNak  = 8'h15;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StChk,
        StWrite,
        StReadWait,
        StResp
    } loader_state_e;

endpackage

// File: rtl/loader_tx_serializer.sv
// Emits 1 or 4 bytes of a word MSB first over a valid/ready byte port; done pulses on the last byte.
module loader_tx_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        four,
    input  logic [31:0] word,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        done
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  left_q, left_d;

    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        done    = 1'b0;
        if (load) begin
            shift_d = four ? word : {word[7:0], 24'h0};
            left_d  = four ? 3'd4 : 3'd1;
        end else if (left_q != 3'd0 && txReady) begin
            shift_d = {shift_q[23:0], 8'h0};
            left_d  = left_q - 3'd1;
            done    = (left_q == 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= 32'h0;
            left_q  <= 3'd0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
        end
    end

    assign txValid = (left_q != 3'd0);
    assign txData  = shift_q[31:24];

endmodule

// File: rtl/serial_memory_loader.sv
// Host-side command decoder driving the external memory port from a UART byte stream.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum byte to write frames.
module serial_memory_loader
    import serial_memory_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          PAUSE_ON_RESET = 1'b1,
    parameter logic [2:0]  MEM_WORD_MODE  = 3'b011,
    parameter logic [2:0]  MEM_NONE_MODE  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic        rxReady,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        pause,
    output logic        externalMemoryControl,
    output logic [31:0] externalAddress,
    output logic [31:0] externalData,
    output logic [2:0]  externalReadMode,
    output logic [2:0]  externalWriteMode,
    input  logic [31:0] externalDataOut,
    output logic        busy,
    output logic        frameError
);

    loader_state_e state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [31:0]   lat_q, lat_d;
    logic          is_write_q, is_write_d;
    logic          pause_q, emc_q, pause_d;
    logic          fe_q, fe_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    logic          rx_fire;
    logic          tmo_hit;
    logic          tx_load, tx_four, tx_done;
    logic [31:0]   tx_word;

    assign rxReady = (state_q == StIdle) || (state_q == StAddr) ||
                     (state_q == StData) || (state_q == StChk);
    assign rx_fire = rxReady && rxValid;
    assign tmo_hit = !rx_fire && (tmo_q == TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        is_write_d = is_write_q;
        pause_d    = pause_q;
        lat_d      = 32'd0;
        fe_d       = 1'b0;
        tx_load    = 1'b0;
        tx_four    = 1'b0;
        tx_word    = {24'h0, RespAck};
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        // Idle gap counter only runs while a frame is being received.
        if (rx_fire || !((state_q == StAddr) || (state_q == StData) || (state_q == StChk))) begin
            tmo_d = 32'd0;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d = rxData;
`endif
                    case (rxData)
                        CmdWrite: begin
                            is_write_d = 1'b1;
                            pause_d    = 1'b1;
                            state_d    = StAddr;
                        end
                        CmdRead: begin
                            is_write_d = 1'b0;
                            pause_d    = 1'b1;
                            state_d    = StAddr;
                        end
                        CmdPause: begin
                            pause_d = 1'b1;
                            tx_load = 1'b1;
                            state_d = StResp;
                        end
                        CmdGo: begin
                            pause_d = 1'b0;
                            tx_load = 1'b1;
                            state_d = StResp;
                        end
                        default: fe_d = 1'b1;
                    endcase
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d = {addr_q[23:0], rxData};
                    cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ rxData;
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = is_write_q ? StData : StReadWait;
                    end
                end else if (tmo_hit) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StData: begin
                if (rx_fire) begin
                    data_d = {data_q[23:0], rxData};
                    cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ rxData;
                    if (cnt_q == 2'd3) state_d = StChk;
`else
                    if (cnt_q == 2'd3) state_d = StWrite;
`endif
                end else if (tmo_hit) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StChk: begin
`ifdef LOADER_CHECKSUM_EN
                if (rx_fire) begin
                    if (rxData == chk_q) begin
                        state_d = StWrite;
                    end else begin
                        tx_load = 1'b1;
                        tx_word = {24'h0, RespNak};
                        state_d = StResp;
                    end
                end else if (tmo_hit) begin
                    fe_d    = 1'b1;
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            StWrite: begin
                tx_load = 1'b1;
                state_d = StResp;
            end
            StReadWait: begin
                lat_d = lat_q + 32'd1;
                if (lat_q == READ_LATENCY - 1) begin
                    tx_load = 1'b1;
                    tx_four = 1'b1;
                    tx_word = externalDataOut;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (tx_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            tmo_q      <= 32'd0;
            lat_q      <= 32'd0;
            is_write_q <= 1'b0;
            pause_q    <= PAUSE_ON_RESET;
            emc_q      <= PAUSE_ON_RESET;
            fe_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= 8'h0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            lat_q      <= lat_d;
            is_write_q <= is_write_d;
            pause_q    <= pause_d;
            emc_q      <= pause_d;
            fe_q       <= fe_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    loader_tx_serializer u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (tx_load),
        .four    (tx_four),
        .word    (tx_word),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady),
        .done    (tx_done)
    );

    assign pause                 = pause_q;
    assign externalMemoryControl = emc_q;
    assign externalAddress       = addr_q;
    assign externalData          = data_q;
    assign externalWriteMode     = (state_q == StWrite) ? MEM_WORD_MODE : MEM_NONE_MODE;
    assign externalReadMode      = (state_q == StReadWait) ? MEM_WORD_MODE : MEM_NONE_MODE;
    assign busy                  = (state_q != StIdle);
    assign frameError            = fe_q;

endmodule

// File: tb/tb_serial_memory_loader.sv
// Scoreboard bench for serial_memory_loader: directed frames, queued expected tx bytes and writes.
module tb_serial_memory_loader;

    localparam int unsigned TMO = 40;
    localparam int unsigned RLAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        pause;
    logic        externalMemoryControl;
    logic [31:0] externalAddress;
    logic [31:0] externalData;
    logic [2:0]  externalReadMode;
    logic [2:0]  externalWriteMode;
    logic [31:0] externalDataOut;
    logic        busy;
    logic        frameError;

    int vectors = 0;
    int miscompares = 0;
    int fe_cycles = 0;
    int rd_cycles = 0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] mem_word = 32'h0;
    logic [31:0] exp_raddr = 32'h0;

    always #5 clk = ~clk;

    serial_memory_loader #(
        .TIMEOUT_CYCLES (TMO),
        .READ_LATENCY   (RLAT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rxData                (rxData),
        .rxValid               (rxValid),
        .rxReady               (rxReady),
        .txData                (txData),
        .txValid               (txValid),
        .txReady               (txReady),
        .pause                 (pause),
        .externalMemoryControl (externalMemoryControl),
        .externalAddress       (externalAddress),
        .externalData          (externalData),
        .externalReadMode      (externalReadMode),
        .externalWriteMode     (externalWriteMode),
        .externalDataOut       (externalDataOut),
        .busy                  (busy),
        .frameError            (frameError)
    );

    // Simple one-word memory: read data only presented while a read is requested.
    always @(posedge clk) if (externalWriteMode == 3'b011) mem_word <= externalData;
    assign externalDataOut = (externalReadMode == 3'b011) ? mem_word : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboards whenever the DUT presents a tx byte or a memory write.
    always @(negedge clk) begin
        if (frameError) fe_cycles++;
        if (externalReadMode !== 3'b000) begin
            rd_cycles++;
            check("read_mode", {29'h0, externalReadMode}, 32'h3);
            check("read_addr", externalAddress, exp_raddr);
        end
        if (txValid && txReady) begin
            if (exp_tx.size() == 0) check("unexpected_tx", {24'h0, txData}, 32'hffff_ffff);
            else check("tx_byte", {24'h0, txData}, {24'h0, exp_tx.pop_front()});
        end
        if (externalWriteMode !== 3'b000) begin
            check("write_mode", {29'h0, externalWriteMode}, 32'h3);
            if (exp_wr.size() == 0) begin
                check("unexpected_write", externalAddress, 32'hffff_ffff);
            end else begin
                logic [63:0] w;
                w = exp_wr.pop_front();
                check("write_addr", externalAddress, w[63:32]);
                check("write_data", externalData, w[31:0]);
            end
        end
    end

    // Called at a negedge; returns at a negedge after the byte was consumed.
    task automatic send(input logic [7:0] b);
        int n = 0;
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rx_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_tx.size() == 0 && !busy && !txValid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", {31'h0, n < 300}, 32'd1);
    endtask

    task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] ck;
        ck = 8'h57 ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        send(8'h57);
        for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
`ifdef LOADER_CHECKSUM_EN
        send(ck);
`else
        if (ck == 8'h00) rxData = 8'h00;
`endif
    endtask

    initial begin
        int fe0;
        int rd0;
        rst     = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        txReady = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pause", {31'h0, pause}, 32'd1);
        check("rst_emc", {31'h0, externalMemoryControl}, 32'd1);
        check("rst_txvalid", {31'h0, txValid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_fe", {31'h0, frameError}, 32'd0);
        check("rst_addr", externalAddress, 32'h0);
        check("rst_data", externalData, 32'h0);
        check("rst_modes", {26'h0, externalReadMode, externalWriteMode}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rxready", {31'h0, rxReady}, 32'd1);

        // Word write
        exp_wr.push_back({32'h0000_0010, 32'hDEAD_BEEF});
        exp_tx.push_back(8'h06);
        write_frame(32'h0000_0010, 32'hDEAD_BEEF);
        drain();
        check("write_done", exp_wr.size(), 32'd0);
        check("pause_after_w", {31'h0, pause}, 32'd1);

        // Word read
        rd0 = rd_cycles;
        exp_raddr = 32'h0000_0010;
        exp_tx.push_back(8'hDE);
        exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        send(8'h52);
        for (int i = 0; i < 4; i++) send((i == 3) ? 8'h10 : 8'h00);
        drain();
        check("read_cycles", rd_cycles - rd0, RLAT);

        // Go then pause
        exp_tx.push_back(8'h06);
        send(8'h47);
        drain();
        check("go_pause", {31'h0, pause}, 32'd0);
        check("go_emc", {31'h0, externalMemoryControl}, 32'd0);
        exp_tx.push_back(8'h06);
        send(8'h50);
        drain();
        check("p_pause", {31'h0, pause}, 32'd1);
        check("p_emc", {31'h0, externalMemoryControl}, 32'd1);

        // Timeout mid-frame
        fe0 = fe_cycles;
        send(8'h57);
        send(8'h00);
        send(8'h00);
        repeat (TMO + 10) @(negedge clk);
        check("tmo_fe", fe_cycles - fe0, 32'd1);
        check("tmo_busy", {31'h0, busy}, 32'd0);
        check("tmo_pause", {31'h0, pause}, 32'd1);
        exp_tx.push_back(8'h06);
        send(8'h47);
        drain();
        check("after_tmo_go", {31'h0, pause}, 32'd0);

        // Bad command byte
        fe0 = fe_cycles;
        send(8'h41);
        repeat (4) @(negedge clk);
        check("bad_cmd_fe", fe_cycles - fe0, 32'd1);
        check("bad_cmd_busy", {31'h0, busy}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        exp_tx.push_back(8'h15);
        send(8'h57);
        for (int i = 0; i < 8; i++) send(8'h11);
        send(8'hAA);
        drain();
`endif

        // Transmitter back-pressure
        txReady = 1'b0;
        exp_tx.push_back(8'h06);
        send(8'h47);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", {31'h0, txValid}, 32'd1);
            check("hold_data", {24'h0, txData}, 32'h06);
            @(negedge clk);
        end
        txReady = 1'b1;
        drain();

        // Reset during second data byte
        send(8'h57);
        for (int i = 0; i < 4; i++) send(8'h20);
        send(8'h55);
        rxData  = 8'h66;
        rxValid = 1'b1;
        #2 rst = 1'b0;
        #1;
        rxValid = 1'b0;
        check("mid_rst_pause", {31'h0, pause}, 32'd1);
        check("mid_rst_emc", {31'h0, externalMemoryControl}, 32'd1);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_addr", externalAddress, 32'h0);
        check("mid_rst_data", externalData, 32'h0);
        check("mid_rst_txvalid", {31'h0, txValid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_tx.push_back(8'h06);
        send(8'h47);
        drain();
        check("final_pause", {31'h0, pause}, 32'd0);
        check("left_writes", exp_wr.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
